logic_wave_arb: RTL and testbench
=================================

// Module: logic_wave_arb
// PURPOSE
//  Downstream of the per-channel logic controllers. Turns their 8 req_Wave outputs (logics_wave_req) into
//  serialized wave-generation jobs: rising edges are captured as pending events, arbitrated round-robin,
//  issued one at a time to the wave generator with a start/done handshake, and guarded by a timeout.
//  Lost or duplicate events are flagged per channel for host readback.
// PARAMETERS
//  N_CH   8      number of logic channels (1..8)
//  IDX_W  3      width of channel index, >= clog2(N_CH)
//  TMO    1000   max WAIT cycles before abort; 16-bit counter, 2..65535
// PORTS
//  clk              in   1      system clock
//  rst              in   1      reset, synchronous, active-high
//  logics_wave_req  in   N_CH   per-channel wave request levels; bit i = channel i+1
//  ch_en            in   N_CH   per-channel enable; 0 = ignore events and clear pending
//  wave_done        in   1      1-cycle pulse from wave generator: current job finished
//  ovf_clr          in   1      1-cycle pulse: clear ovf and tmo_err
//  wave_start       out  1      1-cycle pulse: issue job on wave_ch
//  wave_ch          out  IDX_W  channel index of issued/active job, held until next issue
//  arb_busy         out  1      high in ISSUE and WAIT
//  pend             out  N_CH   pending-event bitmap
//  ovf              out  N_CH   sticky: event arrived while channel already pending
//  tmo_err          out  1      sticky: a job timed out
// BEHAVIOUR
//  Reset: synchronous, active-high, applied to all state.
//   - Outputs: wave_start=0, wave_ch=0, arb_busy=0, pend=0, ovf=0, tmo_err=0.
//   - State: state=IDLE; last_grant=N_CH-1, so ch0 has first priority; tmo counter=0.
//   - prev_req loads logics_wave_req during reset, so a level held through reset is not an event.
//   - Reset mid-job abandons the job silently; no tmo_err is set.
//  Edge capture: ev[i] = req[i] & ~prev_req[i] & ch_en[i]; prev_req <= req every cycle.
//   - ev[i]=1 -> pend[i] set.
//   - ev[i]=1 while pend[i] already 1 and not being granted this cycle -> ovf[i] set; pend stays 1.
//   - ch_en[i]=0 -> pend[i] cleared, priority over set.
//   - ovf_clr clears ovf/tmo_err; a same-cycle new ovf or timeout wins over the clear.
//  FSM:
//   - IDLE: if (pend & ch_en) != 0, grant the first set bit searching upward from last_grant+1 mod N_CH.
//     Clear pend[g], set wave_ch=g and last_grant=g, go to ISSUE.
//   - ISSUE: wave_start=1 for exactly this cycle, then go to WAIT, counter=0.
//   - WAIT: on wave_done go to IDLE. Else counter++; if counter==TMO-1, set tmo_err and go to IDLE.
//   - wave_done outside WAIT is ignored.
//  Latency: req rises, sampled at edge k -> pend at k -> ISSUE after k+1.
//   - wave_start is high in the cycle following edge k+1 (2 cycles), when idle with nothing pending.
//   - Back-to-back: done at edge d -> IDLE -> next wave_start 2 cycles after d.
//  Simultaneous events:
//   - Event on channel g in its grant cycle: pend[g] clear and set coincide -> pend[g]=1, no ovf (new job queued).
//   - Several events in one cycle: all latched; served in round-robin order.
//  Widths: counter 16 bit, never wraps (aborts at TMO-1); last_grant wraps N_CH-1 -> 0.
// TESTING
//  1. Reset with req=8'hFF held, release rst, hold req -> no wave_start, pend=0.
//  2. req[2] 0->1 once, en=FF -> wave_start after 2 cycles, wave_ch=2; done 5 cycles later -> arb_busy=0.
//  3. req=8'h91 rise together -> issue order ch0, ch4, ch7; then a ch0 event re-served after ch7 (RR wrap).
//  4. ch3 rises twice while ch5 job active -> ovf=8'h08, ch3 served once; ovf_clr -> ovf=0.
//  5. TMO=16, no done -> tmo_err=1 after 16 WAIT cycles, FSM IDLE, next pending job issues.
//  6. rst pulsed during WAIT then done arrives -> ignored; all outputs at reset values, tmo_err=0.

Source files
------------

// File: rtl/logic_wave_arb.sv
// logic_wave_arb
//   Serialises wave-generation requests from the per-channel logic controllers.
//   Rising edges on logics_wave_req become pending events. Pending events are
//   granted round-robin and issued one at a time to the wave generator, using
//   a start/done handshake. A job that never completes is aborted after TMO
//   cycles in WAIT.
//
// Ports
//   clk              system clock
//   rst              synchronous, active-high reset
//   logics_wave_req  per-channel request levels (bit i = channel i+1)
//   ch_en            per-channel enable; a disabled channel loses its pending event
//   wave_done        1-cycle pulse: the active job has finished
//   ovf_clr          1-cycle pulse: clears ovf and tmo_err
//   wave_start       1-cycle pulse: issue the job on wave_ch
//   wave_ch          index of the issued/active job, held until the next issue
//   arb_busy         a job is being issued or is in flight
//   pend             pending-event bitmap
//   ovf              sticky: an event arrived on a channel that was already pending
//   tmo_err          sticky: a job timed out
//
// state | meaning
// IDLE  | no job in flight; grant the next pending channel, if there is one
// ISSUE | wave_start asserted for this single cycle
// WAIT  | waiting for wave_done; counting toward the timeout
module logic_wave_arb #(
  parameter int N_CH  = 8,
  parameter int IDX_W = 3,
  parameter int TMO   = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  logics_wave_req,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             wave_done,
  input  logic             ovf_clr,
  output logic             wave_start,
  output logic [IDX_W-1:0] wave_ch,
  output logic             arb_busy,
  output logic [N_CH-1:0]  pend,
  output logic [N_CH-1:0]  ovf,
  output logic             tmo_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state, state_nx;
  logic [N_CH-1:0]   prev_req;
  logic [N_CH-1:0]   ev;
  logic [N_CH-1:0]   avail;
  logic [N_CH-1:0]   grant_oh;
  logic [N_CH-1:0]   ovf_set;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_ok;
  logic              do_grant;
  logic              tmo_hit;
  logic [15:0]       cnt;

  assign ev    = logics_wave_req & ~prev_req & ch_en;
  assign avail = pend & ch_en;

  // Round-robin search: start one past the last grant and wrap around.
  // The final step (k = N_CH) revisits last_grant itself, so a lone
  // requester is still served.
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= N_CH; k++) begin
      if (!grant_ok && avail[(int'(last_grant) + k) % N_CH]) begin
        grant_ok  = 1'b1;
        grant_idx = IDX_W'((int'(last_grant) + k) % N_CH);
      end
    end
  end

  always_comb begin
    state_nx = state;
    do_grant = 1'b0;
    tmo_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_ok) begin
          do_grant = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (wave_done) begin
          state_nx = IDLE;
        end else if (cnt == 16'(TMO - 1)) begin
          tmo_hit  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    grant_oh = '0;
    if (do_grant) grant_oh[grant_idx] = 1'b1;
  end

  // A channel that is being granted in this same cycle is not an overflow.
  // A new event on that channel simply re-queues it.
  assign ovf_set = ev & pend & ~grant_oh;

  assign wave_start = (state == ISSUE);
  assign arb_busy   = (state != IDLE);

  // prev_req tracks the inputs even during reset, so a level that is held
  // through reset does not count as an edge.
  always_ff @(posedge clk) begin
    prev_req <= logics_wave_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pend       <= '0;
      ovf        <= '0;
      tmo_err    <= 1'b0;
      wave_ch    <= '0;
      last_grant <= IDX_W'(N_CH - 1);
      cnt        <= '0;
    end else begin
      state   <= state_nx;
      // The event set wins over the grant clear; disabling the channel wins over both.
      pend    <= ((pend & ~grant_oh) | ev) & ch_en;
      ovf     <= (ovf & ~{N_CH{ovf_clr}}) | ovf_set;
      tmo_err <= (tmo_err & ~ovf_clr) | tmo_hit;
      if (do_grant) begin
        wave_ch    <= grant_idx;
        last_grant <= grant_idx;
      end
      if (state == ISSUE) begin
        cnt <= '0;
      end else if (state == WAIT && !wave_done && !tmo_hit) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_logic_wave_arb.sv
module tb_logic_wave_arb;

  localparam int N_CH  = 8;
  localparam int IDX_W = 3;
  localparam int TMO   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_CH-1:0]  logics_wave_req;
  logic [N_CH-1:0]  ch_en;
  logic             wave_done;
  logic             ovf_clr;
  logic             wave_start;
  logic [IDX_W-1:0] wave_ch;
  logic             arb_busy;
  logic [N_CH-1:0]  pend;
  logic [N_CH-1:0]  ovf;
  logic             tmo_err;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  logic_wave_arb #(.N_CH(N_CH), .IDX_W(IDX_W), .TMO(TMO)) dut (
    .clk             (clk),
    .rst             (rst),
    .logics_wave_req (logics_wave_req),
    .ch_en           (ch_en),
    .wave_done       (wave_done),
    .ovf_clr         (ovf_clr),
    .wave_start      (wave_start),
    .wave_ch         (wave_ch),
    .arb_busy        (arb_busy),
    .pend            (pend),
    .ovf             (ovf),
    .tmo_err         (tmo_err)
  );

  always #5 clk = ~clk;

  // Scoreboard: every issue must match the next channel that was queued
  // when the stimulus was driven.
  always @(negedge clk) begin
    if (wave_start === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_issue wave_ch=%0d expected no issue", wave_ch);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (wave_ch !== IDX_W'(e)) begin
          failures++;
          $display("FAIL issue_order wave_ch=%0d expected %0d", wave_ch, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    wave_done = 1'b1;
    tick();
    wave_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic await_issue(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cyc && !ok; c++) begin
      @(negedge clk);
      if (wave_start === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit bad;
    rst = 1'b1; logics_wave_req = 8'hFF; ch_en = 8'hFF; wave_done = 0; ovf_clr = 0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({wave_start, wave_ch, arb_busy, pend, ovf, tmo_err} !== '0) begin
      failures++;
      $display("FAIL reset_values ws=%b ch=%0d busy=%b pend=%h ovf=%h tmo=%b expected all 0",
               wave_start, wave_ch, arb_busy, pend, ovf, tmo_err);
    end
    tick();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (wave_start !== 1'b0 || pend !== 8'h00 || arb_busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL held_req_no_event pend=%h ws=%b expected pend=00 ws=0", pend, wave_start);
    end
    tick();
    logics_wave_req = 8'h00;
    tick();
  endtask

  task automatic test_single();
    exp_q.push_back(2);
    logics_wave_req = 8'h04;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (pend !== 8'h04 || wave_start !== 1'b0) begin
      failures++;
      $display("FAIL single_pend pend=%h ws=%b expected pend=04 ws=0", pend, wave_start);
    end
    @(negedge clk);
    checks++;
    if (wave_start !== 1'b1 || wave_ch !== 3'd2 || pend !== 8'h00 || arb_busy !== 1'b1) begin
      failures++;
      $display("FAIL single_issue ws=%b ch=%0d pend=%h busy=%b expected 1/2/00/1",
               wave_start, wave_ch, pend, arb_busy);
    end
    tick();
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (arb_busy !== 1'b1 || wave_start !== 1'b0) begin
      failures++;
      $display("FAIL single_wait busy=%b ws=%b expected busy=1 ws=0", arb_busy, wave_start);
    end
    wave_done = 1'b1;
    tick();
    wave_done = 1'b0;
    @(negedge clk);
    checks++;
    if (arb_busy !== 1'b0 || wave_ch !== 3'd2) begin
      failures++;
      $display("FAIL single_done busy=%b ch=%0d expected busy=0 ch=2", arb_busy, wave_ch);
    end
    logics_wave_req = 8'h00;
    tick();
  endtask

  task automatic test_rr();
    bit ok;
    do_reset();
    exp_q.push_back(0); exp_q.push_back(4); exp_q.push_back(7);
    logics_wave_req = 8'h91;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (pend !== 8'h91) begin
      failures++;
      $display("FAIL rr_pend pend=%h expected 91", pend);
    end
    await_issue(4, ok);
    checks++;
    if (!ok || pend !== 8'h90) begin
      failures++;
      $display("FAIL rr_first_issue ok=%b pend=%h expected ok=1 pend=90", ok, pend);
    end
    tick(); pulse_done();
    await_issue(4, ok);
    tick(); pulse_done();
    await_issue(4, ok);
    checks++;
    if (!ok || pend !== 8'h00) begin
      failures++;
      $display("FAIL rr_third_issue ok=%b pend=%h expected ok=1 pend=00", ok, pend);
    end
    tick();
    logics_wave_req = 8'h90;
    tick();
    exp_q.push_back(0);
    logics_wave_req = 8'h91;
    tick();
    pulse_done();
    await_issue(4, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rr_wrap_issue got no issue expected ch0 issue");
    end
    tick(); pulse_done();
    logics_wave_req = 8'h00;
    tick();
  endtask

  task automatic test_ovf();
    bit ok;
    exp_q.push_back(5);
    logics_wave_req = 8'h20;
    await_issue(4, ok);
    tick();
    logics_wave_req = 8'h28; tick();
    logics_wave_req = 8'h20; tick();
    logics_wave_req = 8'h28; tick();
    @(negedge clk);
    checks++;
    if (ovf !== 8'h08 || pend !== 8'h08 || arb_busy !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set ovf=%h pend=%h busy=%b expected 08/08/1", ovf, pend, arb_busy);
    end
    exp_q.push_back(3);
    tick();
    pulse_done();
    await_issue(4, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL ovf_serve got no issue expected ch3 issue");
    end
    tick(); pulse_done();
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (ovf !== 8'h08 || pend !== 8'h00) begin
      failures++;
      $display("FAIL ovf_sticky ovf=%h pend=%h expected 08/00", ovf, pend);
    end
    tick();
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (ovf !== 8'h00) begin
      failures++;
      $display("FAIL ovf_clear ovf=%h expected 00", ovf);
    end
    logics_wave_req = 8'h00;
    tick();
  endtask

  task automatic test_ch_en();
    bit ok;
    exp_q.push_back(5);
    logics_wave_req = 8'h20;
    await_issue(4, ok);
    tick();
    logics_wave_req = 8'h22;
    tick();
    @(negedge clk);
    checks++;
    if (pend !== 8'h02) begin
      failures++;
      $display("FAIL en_pend pend=%h expected 02", pend);
    end
    ch_en = 8'hFD;
    tick();
    @(negedge clk);
    checks++;
    if (pend !== 8'h00) begin
      failures++;
      $display("FAIL en_clear pend=%h expected 00", pend);
    end
    ch_en = 8'hFF;
    tick();
    pulse_done();
    repeat (6) tick();
    logics_wave_req = 8'h00;
    tick();
  endtask

  task automatic test_timeout();
    bit ok, bad;
    exp_q.push_back(6);
    logics_wave_req = 8'h40;
    await_issue(4, ok);
    bad = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (arb_busy !== 1'b1 || tmo_err !== 1'b0) bad = 1'b1;
      if (i == 3) begin
        exp_q.push_back(1);
        logics_wave_req = 8'h42;
      end
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL tmo_early busy=%b tmo=%b expected busy=1 tmo=0 for all WAIT cycles", arb_busy, tmo_err);
    end
    @(negedge clk);
    checks++;
    if (arb_busy !== 1'b0 || tmo_err !== 1'b1 || pend !== 8'h02) begin
      failures++;
      $display("FAIL tmo_abort busy=%b tmo=%b pend=%h expected 0/1/02", arb_busy, tmo_err, pend);
    end
    await_issue(3, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL tmo_next_issue got no issue expected ch1 issue");
    end
    tick(); pulse_done();
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (tmo_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_clear tmo=%b expected 0", tmo_err);
    end
    logics_wave_req = 8'h00;
    tick();
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    exp_q.push_back(2);
    logics_wave_req = 8'h04;
    await_issue(4, ok);
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    wave_done = 1'b1; tick(); wave_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({wave_start, wave_ch, arb_busy, pend, ovf, tmo_err} !== '0) begin
      failures++;
      $display("FAIL reset_mid_job ws=%b ch=%0d busy=%b pend=%h ovf=%h tmo=%b expected all 0",
               wave_start, wave_ch, arb_busy, pend, ovf, tmo_err);
    end
    repeat (TMO + 4) tick();
    @(negedge clk);
    checks++;
    if (tmo_err !== 1'b0 || arb_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_tmo tmo=%b busy=%b expected 0/0", tmo_err, arb_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_ovf();
    test_ch_en();
    test_timeout();
    test_reset_mid_job();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_issues left=%0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
